ysyx_22040237_ifu: RTL and testbench

YSYX_22040237_IFU -- requirements
Module: ysyx_22040237_ifu

---
 rtl/ysyx_22040237_pkg.sv | 17 +
 rtl/ysyx_22040237_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_pkg.sv
// Shared types and constants for the ysyx_22040237 instruction fetch unit.
// Holds the fetch FSM state encoding and the default reset fetch address.
package ysyx_22040237_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned XLEN   = 64;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_REQ,
        IFU_WAIT,
        IFU_HOLD,
        IFU_HALT
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: single outstanding request to instruction memory,
// presents pc/inst to decode, handles redirects, stops fetching after ebreak.
module ysyx_22040237_ifu
    import ysyx_22040237_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       pc,
    output logic [INST_W-1:0] inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              halted
);

    ifu_state_e        state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [31:0]       redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        pc_d       = pc_q;
        inst_d     = inst_q;

        unique case (state_q)
            IFU_REQ: begin
                if (imem_req_ready) begin
                    state_d = IFU_WAIT;
                end
                // A redirect racing an accepted request must squash that request's response.
                if (redirect_valid) begin
                    fetch_pc_d = redirect_aligned;
                    if (imem_req_ready) begin
                        drop_d = 1'b1;
                    end
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_aligned;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        inst_d  = imem_rsp_data;
                        pc_d    = fetch_pc_q;
                        state_d = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                // halt on a consumed instruction beats redirect; redirect beats the +4 advance.
                if (inst_ready && halt) begin
                    state_d = IFU_HALT;
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_aligned;
                    state_d    = IFU_REQ;
                end else if (inst_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = IFU_REQ;
                end
            end
            IFU_HALT: begin
                state_d = IFU_HALT;
            end
            default: begin
                state_d = IFU_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IFU_REQ;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    // Gated by rst_n so no request is visible while reset is asserted.
    assign imem_req_valid = rst_n && (state_q == IFU_REQ);
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = (state_q == IFU_HOLD);
    assign halted         = (state_q == IFU_HALT);
    assign pc             = pc_q;
    assign inst           = inst_q;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed self-checking bench for ysyx_22040237_ifu.
module tb_ysyx_22040237_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ysyx_22040237_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .pc             (pc),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;

        // Reset state
        step();
        step();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);

        // Basic fetch: accept, respond next cycle, consume
        rst_n = 1'b1;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h8000_0000);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("hold_pc", pc, 32'h8000_0000);
        check("hold_inst", inst, 32'h0010_0093);

        // Stall in HOLD for 5 cycles; halt without consume is ignored
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_pc", pc, 32'h8000_0000);
            check("stall_inst", inst, 32'h0010_0093);
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        end
        halt       = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("next_req_addr", imem_req_addr, 32'h8000_0004);
        check("next_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Redirect while waiting: response dropped, refetch at aligned target
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        check("wait_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        check("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("drop_req_addr", imem_req_addr, 32'h8000_0100);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("refetch_inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_0113;
        step();
        imem_rsp_valid = 1'b0;
        check("refetch_hold_valid", {31'd0, inst_valid}, 32'd1);
        check("refetch_pc", pc, 32'h8000_0100);
        check("refetch_inst", inst, 32'h0020_0113);

        // Redirect with consume in HOLD: redirect target wins over pc+4
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        check("hold_redir_addr", imem_req_addr, 32'h8000_0200);
        check("hold_redir_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Redirect in REQ without handshake
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0303;
        step();
        redirect_valid = 1'b0;
        check("req_redir_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req_redir_addr", imem_req_addr, 32'h8000_0300);

        // Redirect in REQ with handshake: that response is dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        check("req_hs_drop_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("req_hs_drop_addr", imem_req_addr, 32'hFFFF_FFFC);

        // Fetch at top of address space; pc+4 wraps to zero
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        check("wrap_hold_pc", pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("wrap_addr", imem_req_addr, 32'h0000_0000);

        // ebreak consumed with simultaneous redirect: halt wins
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0073;
        step();
        imem_rsp_valid = 1'b0;
        check("ebreak_inst", inst, 32'h0010_0073);
        inst_ready     = 1'b1;
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        step();
        inst_ready     = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("halt_stays", {31'd0, halted}, 32'd1);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;

        // Reset exits HALT asynchronously
        rst_n = 1'b0;
        #1;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;

        // Reset mid-WAIT with stray response during and after reset
        #2;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBADB_AD00;
        step();
        check("midwait_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("midwait_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("midwait_rst_pc", pc, 32'h0);
        check("midwait_rst_inst", inst, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_rst_addr", imem_req_addr, 32'h8000_0000);
        step();
        imem_rsp_valid = 1'b0;
        check("stray_ignored_valid", {31'd0, inst_valid}, 32'd0);
        check("stray_ignored_inst", inst, 32'h0);
        check("stray_still_req", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0030_0193;
        step();
        imem_rsp_valid = 1'b0;
        check("post_rst_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("post_rst_pc", pc, 32'h8000_0000);
        check("post_rst_inst", inst, 32'h0030_0193);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
